pack_dispatch_alloc: RTL and testbench

// Dispatch-side writer for the 2-slot instruction payload RAM. Accepts decoded instruction pairs

---
 rtl/pack_dispatch_alloc.sv | 149 ++++++++++++++
 tb/tb_pack_dispatch_alloc.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pack_dispatch_alloc.sv
// pack_dispatch_alloc: dispatch-side writer for the 2-slot instruction payload RAM.
// Allocates pack ids from a circular free list, registers the payload for a
// one-cycle-late RAM write, returns ROB ids, and frees packs on commit or flush.
// Optional feature macro: PACK_ALLOC_STATS_EN adds dispatch/stall statistics counters.
module pack_dispatch_alloc #(
  parameter int PID_W = 4
) (
  input  logic             cpu_clk_i,
  input  logic             cpu_resetn_i,
  input  logic             dec_valid_i,
  output logic             dec_ready_o,
  input  logic [47:0]      dec_ins0_i,
  input  logic             dec_ins0_vld_i,
  input  logic [47:0]      dec_ins1_i,
  input  logic             dec_ins1_vld_i,
  output logic [PID_W:0]   rob0_id_o,
  output logic [PID_W:0]   rob1_id_o,
  output logic [PID_W-1:0] pack_id_o,
  output logic [47:0]      ins0_o,
  output logic [47:0]      ins1_o,
  output logic             ins0_valid_o,
  output logic             ins1_valid_o,
  input  logic             commit_i,
  input  logic             flush_i,
  output logic             empty_o,
  output logic             full_o,
  output logic [PID_W:0]   occupancy_o,
  output logic             commit_err_o
`ifdef PACK_ALLOC_STATS_EN
  ,
  output logic [31:0]      stat_disp_o,
  output logic [31:0]      stat_stall_o
`endif
);

  localparam int DEPTH = 1 << PID_W;
  localparam logic [PID_W:0] DEPTH_C = (PID_W+1)'(DEPTH);

  logic [PID_W-1:0] r_tail;
  logic [PID_W-1:0] r_head;
  logic [PID_W:0]   r_count;
  logic [PID_W:0]   w_countNext;
  logic [PID_W-1:0] r_pid;
  logic [47:0]      r_ins0;
  logic [47:0]      r_ins1;
  logic             r_vld0;
  logic             r_vld1;
  logic             r_commitErr;
  logic             w_accept;
  logic             w_commit;
  logic             w_notEmpty;

  // Handshake and free-list qualifiers; ready looks only at the registered count
  assign w_notEmpty  = (r_count != '0);
  assign dec_ready_o = (r_count != DEPTH_C);
  assign w_accept    = dec_valid_i & dec_ready_o & ~flush_i;
  assign w_commit    = commit_i & ~flush_i & w_notEmpty;

  assign rob0_id_o    = {r_tail, 1'b0};
  assign rob1_id_o    = {r_tail, 1'b1};
  assign pack_id_o    = r_pid;
  assign ins0_o       = r_ins0;
  assign ins1_o       = r_ins1;
  // A write sitting in the output register is squashed by a flush in the same cycle
  assign ins0_valid_o = r_vld0 & ~flush_i;
  assign ins1_valid_o = r_vld1 & ~flush_i;
  assign empty_o      = ~w_notEmpty;
  assign full_o       = ~dec_ready_o;
  assign occupancy_o  = r_count;
  assign commit_err_o = r_commitErr;

  // Occupancy update: simultaneous accept and commit cancel out
  always_comb begin
    w_countNext = r_count;
    if (flush_i) begin
      w_countNext = '0;
    end else if (w_accept && !w_commit) begin
      w_countNext = r_count + 1'b1;
    end else if (!w_accept && w_commit) begin
      w_countNext = r_count - 1'b1;
    end
  end

  // Free-list pointers and count; flush rewinds everything to pack 0
  always_ff @(posedge cpu_clk_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      r_tail  <= '0;
      r_head  <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_countNext;
      if (flush_i) begin
        r_tail <= '0;
        r_head <= '0;
      end else begin
        if (w_accept) r_tail <= r_tail + 1'b1;
        if (w_commit) r_head <= r_head + 1'b1;
      end
    end
  end

  // One-deep output register feeding the payload RAM write port
  always_ff @(posedge cpu_clk_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      r_pid  <= '0;
      r_ins0 <= '0;
      r_ins1 <= '0;
      r_vld0 <= 1'b0;
      r_vld1 <= 1'b0;
    end else begin
      r_vld0 <= w_accept & dec_ins0_vld_i;
      r_vld1 <= w_accept & dec_ins1_vld_i;
      if (w_accept) begin
        r_pid  <= r_tail;
        r_ins0 <= dec_ins0_i;
        r_ins1 <= dec_ins1_i;
      end
    end
  end

  // Sticky error flag for a commit arriving with nothing allocated
  always_ff @(posedge cpu_clk_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      r_commitErr <= 1'b0;
    end else if (commit_i && !flush_i && !w_notEmpty) begin
      r_commitErr <= 1'b1;
    end
  end

`ifdef PACK_ALLOC_STATS_EN
  logic [31:0] r_statDisp;
  logic [31:0] r_statStall;

  assign stat_disp_o  = r_statDisp;
  assign stat_stall_o = r_statStall;

  // Free-running statistics; survive flush and wrap naturally
  always_ff @(posedge cpu_clk_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      r_statDisp  <= '0;
      r_statStall <= '0;
    end else begin
      if (w_accept) r_statDisp <= r_statDisp + 32'd1;
      if (dec_valid_i && !dec_ready_o) r_statStall <= r_statStall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pack_dispatch_alloc.sv
// tb_pack_dispatch_alloc: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-based allocator model.
module tb_pack_dispatch_alloc;

  logic        clk;
  logic        rstN;
  logic        decValid;
  logic        decReady;
  logic [47:0] decIns0;
  logic        decIns0Vld;
  logic [47:0] decIns1;
  logic        decIns1Vld;
  logic [4:0]  rob0Id;
  logic [4:0]  rob1Id;
  logic [3:0]  packId;
  logic [47:0] ins0;
  logic [47:0] ins1;
  logic        ins0Valid;
  logic        ins1Valid;
  logic        commit;
  logic        flush;
  logic        empty;
  logic        full;
  logic [4:0]  occupancy;
  logic        commitErr;

  int testsRun = 0;
  int testsFailed = 0;

  pack_dispatch_alloc #(.PID_W(4)) dut (
    .cpu_clk_i     (clk),
    .cpu_resetn_i  (rstN),
    .dec_valid_i   (decValid),
    .dec_ready_o   (decReady),
    .dec_ins0_i    (decIns0),
    .dec_ins0_vld_i(decIns0Vld),
    .dec_ins1_i    (decIns1),
    .dec_ins1_vld_i(decIns1Vld),
    .rob0_id_o     (rob0Id),
    .rob1_id_o     (rob1Id),
    .pack_id_o     (packId),
    .ins0_o        (ins0),
    .ins1_o        (ins1),
    .ins0_valid_o  (ins0Valid),
    .ins1_valid_o  (ins1Valid),
    .commit_i      (commit),
    .flush_i       (flush),
    .empty_o       (empty),
    .full_o        (full),
    .occupancy_o   (occupancy),
    .commit_err_o  (commitErr)
  );

  // 10ns core clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge
  task automatic applyStimulus(input bit v, input bit v0, input bit v1,
                               input bit cm, input bit fl);
    @(posedge clk);
    #1;
    decValid   = v;
    decIns0Vld = v0;
    decIns1Vld = v1;
    decIns0    = 48'({$urandom(), $urandom()});
    decIns1    = 48'({$urandom(), $urandom()});
    commit     = cm;
    flush      = fl;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Behavioural model: in-flight packs as a queue of ids, next id to hand out,
  // sticky error, and the write that will be presented to the RAM next cycle.
  int          inflight[$];
  int          nextId;
  bit          mErr;
  bit          pendV0, pendV1;
  int          pendPid;
  logic [47:0] pendIns0, pendIns1;

  task automatic modelReset();
    inflight.delete();
    nextId  = 0;
    mErr    = 0;
    pendV0  = 0;
    pendV1  = 0;
    pendPid = 0;
  endtask

  // Compare process: check DUT against the model each falling edge, then advance the model
  initial begin
    modelReset();
    forever begin
      @(negedge clk);
      if (!rstN) begin
        modelReset();
        checkOutput("rst_occupancy", occupancy, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_ready", decReady, 1);
        checkOutput("rst_err", commitErr, 0);
        checkOutput("rst_ins0_valid", ins0Valid, 0);
        checkOutput("rst_ins1_valid", ins1Valid, 0);
        checkOutput("rst_pack_id", packId, 0);
      end else begin
        int  oldSize;
        bit  acc;
        bit  expV0, expV1;
        oldSize = inflight.size();
        acc     = decValid && (oldSize < 16) && !flush;
        expV0   = pendV0 && !flush;
        expV1   = pendV1 && !flush;
        checkOutput("m_occupancy", occupancy, oldSize);
        checkOutput("m_empty", empty, oldSize == 0);
        checkOutput("m_full", full, oldSize == 16);
        checkOutput("m_ready", decReady, oldSize < 16);
        checkOutput("m_err", commitErr, mErr);
        checkOutput("m_ins0_valid", ins0Valid, expV0);
        checkOutput("m_ins1_valid", ins1Valid, expV1);
        if (expV0 || expV1) checkOutput("m_pack_id", packId, pendPid);
        if (expV0) checkOutput("m_ins0", ins0, pendIns0);
        if (expV1) checkOutput("m_ins1", ins1, pendIns1);
        if (acc) begin
          checkOutput("m_rob0", rob0Id, nextId * 2);
          checkOutput("m_rob1", rob1Id, nextId * 2 + 1);
        end
        pendV0 = acc && decIns0Vld;
        pendV1 = acc && decIns1Vld;
        if (acc) begin
          pendPid  = nextId;
          pendIns0 = decIns0;
          pendIns1 = decIns1;
        end
        if (flush) begin
          inflight.delete();
          nextId = 0;
        end else begin
          if (commit) begin
            if (oldSize == 0) mErr = 1;
            else void'(inflight.pop_front());
          end
          if (acc) begin
            inflight.push_back(nextId);
            nextId = (nextId + 1) % 16;
          end
        end
      end
    end
  end

  initial begin
    int lastRob;
    decValid = 0; decIns0Vld = 0; decIns1Vld = 0;
    decIns0 = '0; decIns1 = '0; commit = 0; flush = 0;
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;

    // First pack: ROB ids 0/1, RAM write one cycle later
    applyStimulus(1, 1, 1, 0, 0);
    @(negedge clk);
    checkOutput("first_rob0", rob0Id, 0);
    checkOutput("first_rob1", rob1Id, 1);
    idle();
    @(negedge clk);
    checkOutput("first_pack_id", packId, 0);
    checkOutput("first_ins0_valid", ins0Valid, 1);
    checkOutput("first_ins1_valid", ins1Valid, 1);
    idle();
    @(negedge clk);
    checkOutput("first_ins0_pulse", ins0Valid, 0);

    // Fill to 16
    for (int i = 0; i < 15; i++) applyStimulus(1, 1, 1, 0, 0);
    idle();
    @(negedge clk);
    checkOutput("fill_occupancy", occupancy, 16);
    checkOutput("fill_full", full, 1);
    checkOutput("fill_ready", decReady, 0);
    applyStimulus(1, 1, 1, 0, 0);
    idle();
    @(negedge clk);
    checkOutput("stall_no_write", ins0Valid, 0);

    // Full: commit plus offer does not accept this cycle; the retry wraps to pack 0
    applyStimulus(1, 1, 1, 1, 0);
    @(negedge clk);
    checkOutput("full_commit_ready", decReady, 0);
    applyStimulus(1, 1, 1, 0, 0);
    @(negedge clk);
    checkOutput("wrap_rob0", rob0Id, 0);
    idle();
    @(negedge clk);
    checkOutput("wrap_occupancy", occupancy, 16);
    checkOutput("wrap_pack_id", packId, 0);

    // Flush with an offer and a pending write: both are dropped
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0, 1);
    @(negedge clk);
    checkOutput("flush_kill_ins0", ins0Valid, 0);
    checkOutput("flush_kill_ins1", ins1Valid, 0);
    idle();
    @(negedge clk);
    checkOutput("flush_empty", empty, 1);
    checkOutput("flush_no_write", ins0Valid, 0);
    applyStimulus(1, 1, 1, 0, 0);
    @(negedge clk);
    checkOutput("flush_rob0", rob0Id, 0);

    // Commit while empty sets a sticky error
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0);
    idle();
    @(negedge clk);
    checkOutput("err_set", commitErr, 1);
    checkOutput("err_occupancy", occupancy, 0);
    idle(); idle();
    @(negedge clk);
    checkOutput("err_sticky", commitErr, 1);

    // Slot1 empty: only slot0 writes, pointer still advances by one
    applyStimulus(1, 1, 0, 0, 0);
    @(negedge clk);
    lastRob = int'(rob0Id);
    checkOutput("half_rob0", lastRob, 0);
    applyStimulus(1, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("half_ins0_valid", ins0Valid, 1);
    checkOutput("half_ins1_valid", ins1Valid, 0);
    checkOutput("empty_pack_rob0", rob0Id, 2);
    idle();
    @(negedge clk);
    checkOutput("empty_pack_no_write", ins0Valid | ins1Valid, 0);
    checkOutput("empty_pack_occ", occupancy, 2);

    // Asynchronous reset mid-operation
    applyStimulus(1, 1, 1, 0, 0);
    #1 rstN = 1'b0;
    #2;
    checkOutput("async_rst_occ", occupancy, 0);
    checkOutput("async_rst_err", commitErr, 0);
    decValid = 0;
    @(posedge clk);
    #1 rstN = 1'b1;
    applyStimulus(1, 1, 1, 0, 0);
    @(negedge clk);
    checkOutput("post_rst_rob0", rob0Id, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3,
                    $urandom_range(0, 99) < 3);
    end
    idle();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
